// File: rtl/regfile_port_arbiter.sv
// Round-robin read/write port arbiter sharing a 2R/1W register file between two requesters.
// Optional same-cycle write-to-read bypass is compiled in with `define REGFILE_ARB_BYPASS_EN.
module regfile_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [1:0]          rd_req_i,
  input  logic [1:0]          rd_lock_i,
  input  logic [2*ADDR_W-1:0] rd_addr1_i,
  input  logic [2*ADDR_W-1:0] rd_addr2_i,
  output logic [1:0]          rd_gnt_o,
  output logic [1:0]          rsp_v_o,
  output logic [DATA_W-1:0]   rsp_data1_o,
  output logic [DATA_W-1:0]   rsp_data2_o,
  input  logic [1:0]          wr_req_i,
  input  logic [2*ADDR_W-1:0] wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  output logic [1:0]          wr_gnt_o,
  output logic                rf_rd_en_o,
  output logic [ADDR_W-1:0]   rf_rd_addr1_o,
  output logic [ADDR_W-1:0]   rf_rd_addr2_o,
  input  logic [DATA_W-1:0]   rf_rd_data1_i,
  input  logic [DATA_W-1:0]   rf_rd_data2_i,
  output logic                rf_wr_en_o,
  output logic [ADDR_W-1:0]   rf_wr_addr_o,
  output logic [DATA_W-1:0]   rf_wr_data_o
);

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic [1:0] rsp_v_q, rsp_v_d;

  logic rd_any, rd_locked, rd_win, lock_owner;
  logic wr_any, wr_win;

  always_comb begin
    rd_any     = reset_n_i && (|rd_req_i);
    lock_owner = ~rd_ptr_q;
    // The pointer always names the requester that did not win last, so the
    // lock owner is its complement while the counter is live.
    rd_locked  = (lock_cnt_q != '0) && (lock_cnt_q < LOCK_MAX_C) && rd_req_i[lock_owner];
    rd_win     = rd_locked ? lock_owner : ((&rd_req_i) ? rd_ptr_q : rd_req_i[1]);

    wr_any     = reset_n_i && (|wr_req_i);
    wr_win     = (&wr_req_i) ? wr_ptr_q : wr_req_i[1];

    rd_gnt_o      = '0;
    rf_rd_en_o    = 1'b0;
    rf_rd_addr1_o = '0;
    rf_rd_addr2_o = '0;
    rd_ptr_d      = rd_ptr_q;
    lock_cnt_d    = '0;
    if (rd_any) begin
      rd_gnt_o[rd_win] = 1'b1;
      rf_rd_en_o       = 1'b1;
      rf_rd_addr1_o    = rd_win ? rd_addr1_i[2*ADDR_W-1:ADDR_W] : rd_addr1_i[ADDR_W-1:0];
      rf_rd_addr2_o    = rd_win ? rd_addr2_i[2*ADDR_W-1:ADDR_W] : rd_addr2_i[ADDR_W-1:0];
      rd_ptr_d         = ~rd_win;
      if (rd_lock_i[rd_win])
        lock_cnt_d = rd_locked ? lock_cnt_q + 4'd1 : 4'd1;
    end

    wr_gnt_o     = '0;
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    wr_ptr_d     = wr_ptr_q;
    if (wr_any) begin
      wr_gnt_o[wr_win] = 1'b1;
      rf_wr_en_o       = 1'b1;
      rf_wr_addr_o     = wr_win ? wr_addr_i[2*ADDR_W-1:ADDR_W] : wr_addr_i[ADDR_W-1:0];
      rf_wr_data_o     = wr_win ? wr_data_i[2*DATA_W-1:DATA_W] : wr_data_i[DATA_W-1:0];
      wr_ptr_d         = ~wr_win;
    end

    rsp_v_d = rd_gnt_o;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
      rsp_v_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      rsp_v_q    <= rsp_v_d;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  logic              byp1_q, byp1_d;
  logic              byp2_q, byp2_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  always_comb begin
    byp1_d     = rd_any && wr_any && (rf_wr_addr_o == rf_rd_addr1_o);
    byp2_d     = rd_any && wr_any && (rf_wr_addr_o == rf_rd_addr2_o);
    byp_data_d = rf_wr_data_o;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_data_q <= byp_data_d;
    end
  end
`endif

  // Responses are masked while reset is low so an in-flight read never surfaces.
  always_comb begin
    rsp_v_o     = reset_n_i ? rsp_v_q : '0;
    rsp_data1_o = '0;
    rsp_data2_o = '0;
    if (rsp_v_o != '0) begin
`ifdef REGFILE_ARB_BYPASS_EN
      rsp_data1_o = byp1_q ? byp_data_q : rf_rd_data1_i;
      rsp_data2_o = byp2_q ? byp_data_q : rf_rd_data2_i;
`else
      rsp_data1_o = rf_rd_data1_i;
      rsp_data2_o = rf_rd_data2_i;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter with a behavioural 16x16 register file.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  rd_req, rd_lock, wr_req;
  logic [3:0]  a1_0, a2_0, a1_1, a2_1, wa_0, wa_1;
  logic [15:0] wd_0, wd_1;
  logic [1:0]  rd_gnt, rsp_v, wr_gnt;
  logic [15:0] rsp_d1, rsp_d2;
  logic        rf_rd_en, rf_wr_en;
  logic [3:0]  rf_ra1, rf_ra2, rf_wa;
  logic [15:0] rf_rd1, rf_rd2, rf_wd;

  regfile_port_arbiter #(.ADDR_W(4), .DATA_W(16), .LOCK_MAX(8)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .rd_req_i(rd_req), .rd_lock_i(rd_lock),
    .rd_addr1_i({a1_1, a1_0}), .rd_addr2_i({a2_1, a2_0}),
    .rd_gnt_o(rd_gnt), .rsp_v_o(rsp_v),
    .rsp_data1_o(rsp_d1), .rsp_data2_o(rsp_d2),
    .wr_req_i(wr_req), .wr_addr_i({wa_1, wa_0}), .wr_data_i({wd_1, wd_0}),
    .wr_gnt_o(wr_gnt),
    .rf_rd_en_o(rf_rd_en), .rf_rd_addr1_o(rf_ra1), .rf_rd_addr2_o(rf_ra2),
    .rf_rd_data1_i(rf_rd1), .rf_rd_data2_i(rf_rd2),
    .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wa), .rf_wr_data_o(rf_wd)
  );

  always #5 clk = ~clk;

  // Register file: registered read of the pre-write value; reset loads reg[i]=i, reg13=0x01FF.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 13) ? 16'h01FF : 16'(i);
      rf_rd1 <= '0;
      rf_rd2 <= '0;
    end else begin
      if (rf_rd_en) begin
        rf_rd1 <= mem[rf_ra1];
        rf_rd2 <= mem[rf_ra2];
      end
      if (rf_wr_en) mem[rf_wa] <= rf_wd;
    end
  end

  typedef struct packed {
    logic [1:0]  rg;
    logic [1:0]  wg;
    logic        due;
    logic [3:0]  wa;
    logic [15:0] wd;
  } cyc_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [15:0] d1;
    logic [15:0] d2;
  } rsp_t;

  cyc_t cq[$];
  rsp_t rq[$];
  logic pending = 1'b0;
  logic done = 1'b0;
  int   errors, checks;

  task automatic step(input logic [1:0] rg, input logic [1:0] wg,
                      input logic [15:0] d1, input logic [15:0] d2, input logic keep,
                      input logic [3:0] wa, input logic [15:0] wd);
    cq.push_back('{rg: rg, wg: wg, due: pending, wa: wa, wd: wd});
    if (rg != 2'b00 && keep) rq.push_back('{v: rg, d1: d1, d2: d2});
    pending = (rg != 2'b00) && keep;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares grants every cycle and pops the response scoreboard when one is due.
  initial begin
    cyc_t c;
    rsp_t r;
    errors = 0;
    checks = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        chk("rd_gnt", 32'(rd_gnt), 32'(c.rg));
        chk("wr_gnt", 32'(wr_gnt), 32'(c.wg));
        chk("rf_rd_en", 32'(rf_rd_en), 32'(c.rg != 2'b00));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(c.wg != 2'b00));
        if (c.wg != 2'b00) begin
          chk("rf_wr_addr", 32'(rf_wa), 32'(c.wa));
          chk("rf_wr_data", 32'(rf_wd), 32'(c.wd));
        end
        if (c.due) begin
          if (rq.size() == 0) begin
            chk("rsp_queue_empty", 32'd1, 32'd0);
          end else begin
            r = rq.pop_front();
            chk("rsp_v", 32'(rsp_v), 32'(r.v));
            chk("rsp_data1", 32'(rsp_d1), 32'(r.d1));
            chk("rsp_data2", 32'(rsp_d2), 32'(r.d2));
          end
        end else begin
          chk("rsp_v_idle", 32'(rsp_v), 32'd0);
          chk("rsp_data_idle", {rsp_d1, rsp_d2}, 32'd0);
        end
      end
    end
    chk("bench_done", 32'(done), 32'd1);
    chk("rsp_leftover", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [15:0] hz;
    reset_n = 1'b0;
    rd_req = '0; rd_lock = '0; wr_req = '0;
    a1_0 = '0; a2_0 = '0; a1_1 = '0; a2_1 = '0;
    wa_0 = '0; wa_1 = '0; wd_0 = '0; wd_1 = '0;
    @(posedge clk); #1;
    // requests held during reset must not be granted
    rd_req = 2'b11; wr_req = 2'b11;
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);

    reset_n = 1'b1; wr_req = 2'b00;
    rd_req = 2'b01; a1_0 = 4'd13; a2_0 = 4'd1;
    step(2'b01, 2'b00, 16'h01FF, 16'h0001, 1, 0, 0);
    rd_req = 2'b10; a1_1 = 4'd6; a2_1 = 4'd7;
    step(2'b10, 2'b00, 16'h0006, 16'h0007, 1, 0, 0);

    rd_req = 2'b11; a1_0 = 4'd2; a2_0 = 4'd4;
    for (int i = 0; i < 2; i++) begin
      step(2'b01, 2'b00, 16'h0002, 16'h0004, 1, 0, 0);
      step(2'b10, 2'b00, 16'h0006, 16'h0007, 1, 0, 0);
    end

    rd_req = 2'b01;
    step(2'b01, 2'b00, 16'h0002, 16'h0004, 1, 0, 0);
    rd_req = 2'b11; rd_lock = 2'b10;
    a1_0 = 4'd10; a2_0 = 4'd11; a1_1 = 4'd8; a2_1 = 4'd9;
    for (int i = 0; i < 8; i++) step(2'b10, 2'b00, 16'h0008, 16'h0009, 1, 0, 0);
    step(2'b01, 2'b00, 16'h000A, 16'h000B, 1, 0, 0);

    rd_req = 2'b00; rd_lock = 2'b00;
    wr_req = 2'b11; wa_0 = 4'd5; wa_1 = 4'd5; wd_0 = 16'hAAAA; wd_1 = 16'h5555;
    step(2'b00, 2'b01, 0, 0, 1, 4'd5, 16'hAAAA);
    wr_req = 2'b10;
    step(2'b00, 2'b10, 0, 0, 1, 4'd5, 16'h5555);
    wr_req = 2'b00; rd_req = 2'b01; a1_0 = 4'd5; a2_0 = 4'd1;
    step(2'b01, 2'b00, 16'h5555, 16'h0001, 1, 0, 0);

`ifdef REGFILE_ARB_BYPASS_EN
    hz = 16'hBEEF;
`else
    hz = 16'h0003;
`endif
    rd_req = 2'b01; a1_0 = 4'd3; a2_0 = 4'd1;
    wr_req = 2'b01; wa_0 = 4'd3; wd_0 = 16'hBEEF;
    step(2'b01, 2'b01, hz, 16'h0001, 1, 4'd3, 16'hBEEF);

    // read granted, then reset asserted the next cycle: response is dropped
    wr_req = 2'b00; a2_0 = 4'd3;
    step(2'b01, 2'b00, 0, 0, 0, 0, 0);
    reset_n = 1'b0; rd_req = 2'b11; wr_req = 2'b11;
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);
    reset_n = 1'b1; rd_req = 2'b00; wr_req = 2'b00;
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);
    rd_req = 2'b10; a1_1 = 4'd3; a2_1 = 4'd13;
    step(2'b10, 2'b00, 16'h0003, 16'h01FF, 1, 0, 0);
    rd_req = 2'b00;
    step(2'b00, 2'b00, 0, 0, 1, 0, 0);
    done = 1'b1;
  end

endmodule
